run_monitor: RTL and testbench
==============================

# run_monitor

Parametrised, synthesizable run monitor that watches the CPU data-memory write port and PC and decides the outcome of a program run: pass, fail, timeout or hang. It sits beside `cpu` in benches and FPGA bring-up builds, replacing fixed-address pass/fail polling with configurable signature stores, a cycle budget and a stall watchdog. It also keeps cycle and store counters for post-run reporting.

## Interface
- `DATA_W`, 32: width of `dataaddr`, `writedata`, `pc`.
- `CNT_W`, 16: width of cycle and store counters.
- `PASS_ADDR`, 32'd12: store address that signals test completion.
- `PASS_VAL`, 32'd12: value required at `PASS_ADDR` for a pass.
- `FAIL_ADDR`, 32'd13: any store here is a failure.
- `TIMEOUT_CYCLES`, 26: cycle budget; must satisfy 1 ≤ value ≤ 2^CNT_W−1.
- `HANG_CYCLES`, 8: consecutive cycles with unchanged `pc` that count as a hang.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `memwrite` in 1: CPU store strobe.
- `dataaddr` in DATA_W: store address.
- `writedata` in DATA_W: store data.
- `pc` in DATA_W: current CPU PC.
- `done` out 1: run finished; sticky.
- `pass` out 1: run passed; valid when `done`.
- `status` out 3: `run_status_t` code (RUN, PASS, FAIL_ADDR, FAIL_VAL, TIMEOUT, HANG).
- `cycle_cnt` out CNT_W: cycles spent in RUN.
- `store_cnt` out CNT_W: stores observed in RUN; saturating.

## Operation
- FSM states are RUN, PASS, FAIL_ADDR, FAIL_VAL, TIMEOUT and HANG. All except RUN are terminal and absorbing until reset.
- While in RUN, events are evaluated on each sampled cycle:
  - F1: `memwrite && dataaddr==FAIL_ADDR` → FAIL_ADDR.
  - F2: `memwrite && dataaddr==PASS_ADDR && writedata!=PASS_VAL` → FAIL_VAL.
  - P: `memwrite && dataaddr==PASS_ADDR && writedata==PASS_VAL` → PASS.
  - H: the hang condition → HANG.
  - T: `cycle_cnt==TIMEOUT_CYCLES-1` → TIMEOUT.
- Priority when several events occur together: F1 > F2 > P > H > T.
- `cycle_cnt` increments every RUN cycle and freezes on leaving RUN. It reaches at most TIMEOUT_CYCLES−1 and never wraps.
- `store_cnt` increments on each RUN cycle with `memwrite`, including the terminating store. It saturates at all-ones and freezes in terminal states.
- Hang tracking:
  - A stall counter is cleared whenever `pc` differs from the registered previous `pc`, and increments otherwise.
  - H fires when the stall counter reaches HANG_CYCLES−1 and `pc` is still equal.
  - The first cycle after reset never counts as a stall.
- `pass` = (state==PASS). `done` = (state!=RUN).
- `memwrite` with an address other than PASS_ADDR or FAIL_ADDR is counted only.

## Timing
- Reset values: state RUN, `done`=0, `pass`=0, `status`=RUN, `cycle_cnt`=0, `store_cnt`=0, stall counter 0, previous `pc` 0.
- A reset assertion on any edge, including mid-run or after a terminal state, restores all of the above on that edge.
- Latency: an event sampled at edge N is visible on the outputs after edge N (registered, 1 cycle). No combinational paths run from inputs to outputs.
- Timeout: with no other event, `done` rises after the edge on which `cycle_cnt` reaches TIMEOUT_CYCLES−1, i.e. exactly TIMEOUT_CYCLES edges after reset is released.
- No handshake. The monitor is a pure observer and never back-pressures the CPU.

## Configuration
- `RUN_MONITOR_HANG_DETECT_EN` defined: the stall counter, previous-`pc` register and HANG state are built.
- Undefined: that logic is removed, H never fires and HANG is unreachable. The `status` encoding is unchanged and `pc` is ignored.

## Structure
- A shared package `monitor_pkg` holds:
  - `run_status_t` (3-bit enum: RUN=0, PASS=1, FAIL_ADDR=2, FAIL_VAL=3, TIMEOUT=4, HANG=5);
  - default PASS/FAIL address constants.
- One sub-module, `sat_counter`, parametrised by width, with synchronous active-low clear, enable and saturate-at-max. It is used for `store_cnt` and the stall counter.
- The FSM and `cycle_cnt` live in `run_monitor`.

## Test plan
- Store 12 to address 12 at cycle 10 → `done`=1, `pass`=1, `status`=PASS one edge later, `cycle_cnt`=10.
- Store 13 to address 12 → `status`=FAIL_VAL, `pass`=0. A separate run storing any value to address 13 → FAIL_ADDR.
- In the same cycle, `memwrite` to address 13 while the hang threshold hits → FAIL_ADDR (priority check).
- No stores, `pc` advancing each cycle, TIMEOUT_CYCLES=26 → TIMEOUT after exactly 26 edges, `cycle_cnt`=25, `store_cnt`=0.
- `pc` held constant with HANG_CYCLES=8 → HANG when the macro is defined. With the macro undefined → TIMEOUT instead.
- Reset asserted mid-run after 3 stores, then after PASS → all outputs return to reset values on that edge, and a fresh run passes again.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared run-status encoding and default signature addresses for the run monitor.
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_PASS      = 3'd1,
    ST_FAIL_ADDR = 3'd2,
    ST_FAIL_VAL  = 3'd3,
    ST_TIMEOUT   = 3'd4,
    ST_HANG      = 3'd5
  } run_status_t;

  localparam logic [31:0] DEFAULT_PASS_ADDR = 32'd12;
  localparam logic [31:0] DEFAULT_PASS_VAL  = 32'd12;
  localparam logic [31:0] DEFAULT_FAIL_ADDR = 32'd13;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous active-low clear and enable; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Program-run outcome monitor: signature stores, cycle budget and optional stall
// watchdog (built when RUN_MONITOR_HANG_DETECT_EN is defined).
module run_monitor
  import monitor_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 16,
  parameter logic [DATA_W-1:0] PASS_ADDR      = DATA_W'(DEFAULT_PASS_ADDR),
  parameter logic [DATA_W-1:0] PASS_VAL       = DATA_W'(DEFAULT_PASS_VAL),
  parameter logic [DATA_W-1:0] FAIL_ADDR      = DATA_W'(DEFAULT_FAIL_ADDR),
  parameter int                TIMEOUT_CYCLES = 26,
  parameter int                HANG_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] pc,
  output logic              done,
  output logic              pass,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  run_status_t state, next_state;
  logic        fail_addr_hit;
  logic        fail_val_hit;
  logic        pass_hit;
  logic        hang_hit;
  logic        timeout_hit;
  logic        running;

  assign running       = (state == ST_RUN);
  assign fail_addr_hit = memwrite && (dataaddr == FAIL_ADDR);
  assign fail_val_hit  = memwrite && (dataaddr == PASS_ADDR) && (writedata != PASS_VAL);
  assign pass_hit      = memwrite && (dataaddr == PASS_ADDR) && (writedata == PASS_VAL);
  assign timeout_hit   = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef RUN_MONITOR_HANG_DETECT_EN
  localparam int STALL_W = $clog2(HANG_CYCLES + 1);

  logic [DATA_W-1:0]  prev_pc;
  logic               primed;
  logic               pc_same;
  logic [STALL_W-1:0] stall_cnt;

  // primed masks the first post-reset cycle so a PC equal to the reset value of prev_pc is not a stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_pc <= '0;
      primed  <= 1'b0;
    end else begin
      prev_pc <= pc;
      primed  <= 1'b1;
    end
  end

  assign pc_same = primed && (pc == prev_pc);

  sat_counter #(.WIDTH(STALL_W)) u_stall (
    .clk   (clk),
    .clr_n (reset && pc_same),
    .en    (1'b1),
    .count (stall_cnt)
  );

  assign hang_hit = pc_same && (stall_cnt == STALL_W'(HANG_CYCLES - 1));
`else
  logic unused_hang_cfg;
  assign unused_hang_cfg = ^{pc, 32'(HANG_CYCLES)};
  assign hang_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (running) begin
      if (fail_addr_hit) begin
        next_state = ST_FAIL_ADDR;
      end else if (fail_val_hit) begin
        next_state = ST_FAIL_VAL;
      end else if (pass_hit) begin
        next_state = ST_PASS;
      end else if (hang_hit) begin
        next_state = ST_HANG;
      end else if (timeout_hit) begin
        next_state = ST_TIMEOUT;
      end
    end
  end

  // The terminating cycle is not counted, so cycle_cnt tops out at TIMEOUT_CYCLES-1
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (running && (next_state == ST_RUN)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_store (
    .clk   (clk),
    .clr_n (reset),
    .en    (running && memwrite),
    .count (store_cnt)
  );

  assign done   = !running;
  assign pass   = (state == ST_PASS);
  assign status = state;

endmodule

// File: tb/tb_run_monitor.sv
// Directed self-checking bench for run_monitor; expectations adapt to RUN_MONITOR_HANG_DETECT_EN.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataaddr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] pc = '0;
  logic        done;
  logic        pass;
  logic [2:0]  status;
  logic [15:0] cycle_cnt;
  logic [15:0] store_cnt;

  int checks = 0;
  int errors = 0;
  logic pc_adv = 1'b0;

  // Snapshot layout: {done, pass, status[2:0], cycle_cnt[15:0], store_cnt[15:0]}
  logic [36:0] snap;
  assign snap = {done, pass, status, cycle_cnt, store_cnt};

  run_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataaddr  (dataaddr),
    .writedata (writedata),
    .pc        (pc),
    .done      (done),
    .pass      (pass),
    .status    (status),
    .cycle_cnt (cycle_cnt),
    .store_cnt (store_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (pc_adv) pc = pc + 32'd4;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataaddr  = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
    dataaddr  = '0;
    writedata = '0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    memwrite = 1'b0;
    pc       = '0;
    step();
    reset    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    memwrite = 1'b1;
    dataaddr = 32'd12;
    writedata = 32'd12;
    pc = 32'h100;
    step();
    checks++;
    if (snap !== 37'd0) begin
      errors++;
      $display("FAIL reset_with_inputs_active: got %h expected %h", snap, 37'd0);
    end
    do_reset();
    checks++;
    if (snap !== 37'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", snap, 37'd0);
    end
  endtask

  task automatic test_pass();
    do_reset();
    pc_adv = 1'b1;
    repeat (10) step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd10, 16'd0}) begin
      errors++;
      $display("FAIL pass_before_store: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd10, 16'd0});
    end
    store(32'd12, 32'd12);
    checks++;
    if (snap !== {1'b1, 1'b1, 3'd1, 16'd10, 16'd1}) begin
      errors++;
      $display("FAIL pass_outcome: got %h expected %h", snap, {1'b1, 1'b1, 3'd1, 16'd10, 16'd1});
    end
    store(32'd13, 32'd5);
    step();
    checks++;
    if (snap !== {1'b1, 1'b1, 3'd1, 16'd10, 16'd1}) begin
      errors++;
      $display("FAIL pass_absorbing: got %h expected %h", snap, {1'b1, 1'b1, 3'd1, 16'd10, 16'd1});
    end
  endtask

  task automatic test_fail_val();
    do_reset();
    pc_adv = 1'b1;
    repeat (2) step();
    store(32'd100, 32'd7);
    step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd4, 16'd1}) begin
      errors++;
      $display("FAIL other_addr_counted_only: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd4, 16'd1});
    end
    store(32'd12, 32'd13);
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd3, 16'd4, 16'd2}) begin
      errors++;
      $display("FAIL fail_val_outcome: got %h expected %h", snap, {1'b1, 1'b0, 3'd3, 16'd4, 16'd2});
    end
  endtask

  task automatic test_fail_addr();
    do_reset();
    pc_adv = 1'b1;
    repeat (4) step();
    store(32'd13, 32'd12);
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd2, 16'd4, 16'd1}) begin
      errors++;
      $display("FAIL fail_addr_outcome: got %h expected %h", snap, {1'b1, 1'b0, 3'd2, 16'd4, 16'd1});
    end
  endtask

  task automatic test_priority();
    do_reset();
    pc_adv = 1'b0;
    pc = 32'h40;
    repeat (8) step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd8, 16'd0}) begin
      errors++;
      $display("FAIL priority_pre: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd8, 16'd0});
    end
    store(32'd13, 32'd0);
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd2, 16'd8, 16'd1}) begin
      errors++;
      $display("FAIL priority_fail_over_hang: got %h expected %h", snap, {1'b1, 1'b0, 3'd2, 16'd8, 16'd1});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pc_adv = 1'b1;
    repeat (25) step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd25, 16'd0}) begin
      errors++;
      $display("FAIL timeout_edge25: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd25, 16'd0});
    end
    step();
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd4, 16'd25, 16'd0}) begin
      errors++;
      $display("FAIL timeout_edge26: got %h expected %h", snap, {1'b1, 1'b0, 3'd4, 16'd25, 16'd0});
    end
    store(32'd12, 32'd12);
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd4, 16'd25, 16'd0}) begin
      errors++;
      $display("FAIL timeout_absorbing: got %h expected %h", snap, {1'b1, 1'b0, 3'd4, 16'd25, 16'd0});
    end
  endtask

  task automatic test_hang();
    do_reset();
    pc_adv = 1'b0;
    pc = 32'd0;
`ifdef RUN_MONITOR_HANG_DETECT_EN
    repeat (8) step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd8, 16'd0}) begin
      errors++;
      $display("FAIL hang_pre: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd8, 16'd0});
    end
    step();
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd5, 16'd8, 16'd0}) begin
      errors++;
      $display("FAIL hang_outcome: got %h expected %h", snap, {1'b1, 1'b0, 3'd5, 16'd8, 16'd0});
    end
`else
    repeat (25) step();
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd25, 16'd0}) begin
      errors++;
      $display("FAIL nohang_pre: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd25, 16'd0});
    end
    step();
    checks++;
    if (snap !== {1'b1, 1'b0, 3'd4, 16'd25, 16'd0}) begin
      errors++;
      $display("FAIL nohang_timeout: got %h expected %h", snap, {1'b1, 1'b0, 3'd4, 16'd25, 16'd0});
    end
`endif
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pc_adv = 1'b1;
    repeat (3) store(32'd100, 32'd1);
    checks++;
    if (snap !== {1'b0, 1'b0, 3'd0, 16'd3, 16'd3}) begin
      errors++;
      $display("FAIL midrun_stores: got %h expected %h", snap, {1'b0, 1'b0, 3'd0, 16'd3, 16'd3});
    end
    reset = 1'b0;
    step();
    checks++;
    if (snap !== 37'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %h expected %h", snap, 37'd0);
    end
    reset = 1'b1;
    repeat (2) step();
    store(32'd12, 32'd12);
    checks++;
    if (snap !== {1'b1, 1'b1, 3'd1, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL pass_after_midrun_reset: got %h expected %h", snap, {1'b1, 1'b1, 3'd1, 16'd2, 16'd1});
    end
    reset = 1'b0;
    step();
    checks++;
    if (snap !== 37'd0) begin
      errors++;
      $display("FAIL reset_after_pass: got %h expected %h", snap, 37'd0);
    end
    reset = 1'b1;
    repeat (4) step();
    store(32'd12, 32'd12);
    checks++;
    if (snap !== {1'b1, 1'b1, 3'd1, 16'd4, 16'd1}) begin
      errors++;
      $display("FAIL fresh_run_pass: got %h expected %h", snap, {1'b1, 1'b1, 3'd1, 16'd4, 16'd1});
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_val();
    test_fail_addr();
    test_priority();
    test_timeout();
    test_hang();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
